// File: rtl/aucohl_uart_rx_deser_if.sv
// aucohl_uart_rx_deser_if: FIFO write port between rx deserializer and FIFO.
// master = deserializer side, slave = FIFO side.
interface aucohl_uart_rx_deser_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] wdata;
  logic          wr;
  logic          fifo_full;

  modport master (
    output wdata,
    output wr,
    input  fifo_full
  );

  modport slave (
    input  wdata,
    input  wr,
    output fifo_full
  );
endinterface

// File: rtl/aucohl_uart_rx_deser.sv
// aucohl_uart_rx_deser: oversampling serial-frame deserializer into a FIFO.
// Optional parity bit enabled by macro AUCOHL_UART_RX_PARITY_EN.
module aucohl_uart_rx_deser #(
  parameter int DW = 8,
  parameter int OS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic rx,
`ifdef AUCOHL_UART_RX_PARITY_EN
  input  logic parity_odd,
  output logic parity_err,
`endif
  aucohl_uart_rx_deser_if.master fifo,
  output logic frame_err,
  output logic overrun_err,
  output logic busy
);

  localparam int TW = (OS > 2) ? $clog2(OS) : 1;
  localparam int BW = (DW > 2) ? $clog2(DW) : 1;

  localparam logic [TW-1:0] T_END  = TW'(OS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OS / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef AUCOHL_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_q, last_d;
  logic          wr_q, wr_d;
  logic          fe_q, fe_d;
  logic          oe_q, oe_d;
  logic          t_end;
`ifdef AUCOHL_UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          pe_q, pe_d;
  logic          perr;
`endif

  assign t_end = (tcnt_q == T_END);
`ifdef AUCOHL_UART_RX_PARITY_EN
  assign perr  = ((^sh_q) ^ par_q) != parity_odd;
`endif

  // Next-state and output decode; all progress gated by tick, en wins.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    last_d  = last_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    fe_d    = 1'b0;
    oe_d    = 1'b0;
`ifdef AUCOHL_UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    if (!en) begin
      state_d = IDLE;
      tcnt_d  = '0;
      bcnt_d  = '0;
    end else if (tick) begin
      last_d = rx;
      tcnt_d = tcnt_q + TW'(1);
      unique case (state_q)
        IDLE: begin
          tcnt_d = '0;
          if (!rx && last_q) begin
            state_d = START;
          end
        end
        START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = rx ? IDLE : DATA;
          end
        end
        DATA: begin
          if (t_end) begin
            tcnt_d = '0;
            sh_d   = {rx, sh_q[DW-1:1]};
            bcnt_d = bcnt_q + BW'(1);
            if (bcnt_q == B_LAST) begin
`ifdef AUCOHL_UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef AUCOHL_UART_RX_PARITY_EN
        PARITY: begin
          if (t_end) begin
            tcnt_d  = '0;
            par_d   = rx;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          if (t_end) begin
            tcnt_d  = '0;
            state_d = IDLE;
`ifdef AUCOHL_UART_RX_PARITY_EN
            if (perr) begin
              pe_d = 1'b1;
              fe_d = !rx;
            end else
`endif
            if (!rx) begin
              fe_d = 1'b1;
            end else if (fifo.fifo_full) begin
              oe_d = 1'b1;
            end else begin
              wr_d    = 1'b1;
              wdata_d = sh_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  // State, datapath and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
`ifdef AUCOHL_UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
`ifdef AUCOHL_UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign fifo.wdata  = wdata_q;
  assign fifo.wr     = wr_q;
  assign frame_err   = fe_q;
  assign overrun_err = oe_q;
  assign busy        = (state_q != IDLE);
`ifdef AUCOHL_UART_RX_PARITY_EN
  assign parity_err  = pe_q;
`endif

endmodule

// File: doc/aucohl_uart_rx_deser.md
Name: aucohl_uart_rx_deser

Overview:
Oversampling serial-frame deserializer that feeds the codebase FIFO (rx side of UART-style peripherals).
- Takes a synchronized, optionally glitch-filtered serial line and a baud-oversample tick from the ticker.
- Recovers 8N1-style frames, LSB first.
- Emits each recovered word as a single-cycle write strobe plus data, wired directly to the FIFO wr/wdata/full ports.

Parameters:
DW, 8, data bits per frame (5..9).
OS, 16, ticks per bit period (even, 4..64).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  block enable; low forces IDLE.
tick  input  1  oversample strobe, one clk wide, OS per bit.
rx  input  1  serial line, already synchronized to clk.
fifo_full  input  1  downstream FIFO full flag.
wdata  output  DW  received word; connects to FIFO wdata.
wr  output  1  one-cycle write strobe; connects to FIFO wr.
frame_err  output  1  one-cycle pulse: stop bit sampled 0.
overrun_err  output  1  one-cycle pulse: good frame dropped because fifo_full.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wdata=0, wr=0, frame_err=0, overrun_err=0, busy=0; tick counter, bit counter, shift register and last_rx (reset to 1) cleared.
- Reset asserted mid-frame aborts the frame; no strobe or error is issued.
- All state advances only on clk edges where tick=1. Outputs wr, frame_err and overrun_err are registered pulses, never wider than one clk.
- en=0: synchronous return to IDLE on the next clk; counters cleared; pulses forced 0; wdata holds its value.
- last_rx is updated with rx on every tick.
- IDLE: on a tick with rx=0 and last_rx=1 (falling edge), go to START with tick counter=0. A line held low never triggers.
- START: count ticks; on the OS/2-th tick after detection, sample rx.
  - rx=0: go to DATA, bit counter=0.
  - rx=1: false start; go to IDLE with no pulse.
- DATA: sample rx every OS ticks after the previous sample. Shift in LSB first (shift right, new bit into MSB). After DW samples go to STOP.
- STOP: sample rx OS ticks after the last data sample, then return to IDLE in all cases.
  - rx=1 and fifo_full=0: wdata<=shift register and wr=1 on the following clk.
  - rx=1 and fifo_full=1: overrun_err=1; wr stays 0; wdata unchanged.
  - rx=0: frame_err=1; no wr. Because last_rx=0, the next start requires rx to return high (break handling).
- Latency: wr asserts exactly one clk after the tick that samples the stop bit. That is tick index OS/2 + (DW+1)*OS after start detection; 152 for OS=16, DW=8.
- fifo_full is sampled only at the stop-bit tick. The block never buffers more than one word.
- A tick coinciding with en falling is ignored (en has priority).

Optional Feature:
Macro AUCOHL_UART_RX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1: odd, 0: even) and output parity_err (one-cycle pulse).
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled OS ticks after the last data bit, and the stop sample moves OS ticks later.
  - If the XOR of the data bits and the parity bit does not match the selected parity, the stop-bit outcome is replaced: parity_err=1 one clk after the stop-bit tick; no wr, no overrun_err.
  - If the stop bit is also 0, frame_err is pulsed as well.
- Undefined: the parity_odd/parity_err ports and the PARITY state do not exist; frame format is start + DW data + stop.

Test Plan:
- OS=16, DW=8, tick every clk, en=1, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> wr high exactly one cycle, 153 clks after the first low tick, wdata=8'hA5, no error pulses, busy=0 afterwards.
- rx low for 4 ticks then high -> false start: no wr or errors, busy returns to 0 by tick 8; a following 0x3C frame is received correctly.
- Frame 0x55 with stop bit 0, then rx held low 200 ticks, then high, then frame 0x12 -> frame_err one pulse, no wr during the low period, then wr with wdata=8'h12.
- fifo_full=1 during frame 0xFF -> overrun_err one pulse, wr=0, wdata keeps the previous value; next frame with fifo_full=0 is written.
- en dropped at tick 60 of frame 0x81 (or rst_n pulsed mid-frame) -> busy=0 next clk, no wr or errors; all outputs 0 after reset.
- With AUCOHL_UART_RX_PARITY_EN, parity_odd=0: send 0x07 with parity bit 1 -> wr, wdata=8'h07; send 0x07 with parity bit 0 -> parity_err pulse, no wr.
